// File: rtl/fp_cmd_pkg.sv
// Shared opcodes, status-flag positions and sequencer states for the FP command engine.
package fp_cmd_pkg;

  localparam logic [1:0] OpPass = 2'b00;
  localparam logic [1:0] OpNeg  = 2'b01;
  localparam logic [1:0] OpMul  = 2'b10;
  localparam logic [1:0] OpAbs  = 2'b11;

  localparam int unsigned FlagNv   = 4;
  localparam int unsigned FlagOf   = 3;
  localparam int unsigned FlagUf   = 2;
  localparam int unsigned FlagNx   = 1;
  localparam int unsigned FlagZero = 0;

  localparam logic [31:0] CanonNan = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StMult,
    StNorm,
    StPack,
    StHold
  } seq_state_e;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two so pointers wrap freely.
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_mul_cmd_unit.sv
// Queued single-precision command engine: FIFO front end plus a fixed six-state sequencer
// (multiply / negate / abs / pass) with a registered valid/ready result port.
module fp_mul_cmd_unit
  import fp_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [4:0]             res_flags,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int unsigned FifoW = 2 + 64 + TAG_W;

  logic [FifoW-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;

  cmd_fifo #(
    .WIDTH(FifoW),
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (cmd_valid),
    .pop_i  (fifo_pop),
    .wdata_i({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  seq_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic               a_zero_q, a_zero_d, a_inf_q, a_inf_d, a_nan_q, a_nan_d;
  logic               b_zero_q, b_zero_d, b_inf_q, b_inf_d, b_nan_q, b_nan_d;
  logic               sign_q, sign_d;
  logic [47:0]        prod_q, prod_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [22:0]        mant_q, mant_d;
  logic               guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [4:0]         res_flags_q, res_flags_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;

  logic               rnd_up;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        pack_data;
  logic [4:0]         pack_flags;

  // Rounding and special-case resolution, consumed only when the sequencer is in PACK.
  always_comb begin
    rnd_up     = guard_q & (sticky_q | mant_q[0]);
    mant_rnd   = {1'b0, mant_q} + {23'd0, rnd_up};
    exp_rnd    = exp_q + (mant_rnd[23] ? 10'sd1 : 10'sd0);
    pack_data  = a_q;
    pack_flags = '0;
    unique case (op_q)
      OpPass: pack_data = a_q;
      OpNeg:  pack_data = a_nan_q ? a_q : {~a_q[31], a_q[30:0]};
      OpAbs:  pack_data = a_nan_q ? a_q : {1'b0, a_q[30:0]};
      OpMul: begin
        if (a_nan_q || b_nan_q) begin
          pack_data = CanonNan;
        end else if ((a_inf_q && b_zero_q) || (b_inf_q && a_zero_q)) begin
          pack_data          = CanonNan;
          pack_flags[FlagNv] = 1'b1;
        end else if (a_inf_q || b_inf_q) begin
          pack_data = {sign_q, 8'hFF, 23'd0};
        end else if (a_zero_q || b_zero_q) begin
          pack_data = {sign_q, 31'd0};
        end else if (exp_rnd >= 10'sd255) begin
          pack_data          = {sign_q, 8'hFF, 23'd0};
          pack_flags[FlagOf] = 1'b1;
          pack_flags[FlagNx] = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
          pack_data          = {sign_q, 31'd0};
          pack_flags[FlagUf] = 1'b1;
          pack_flags[FlagNx] = 1'b1;
        end else begin
          pack_data          = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
          pack_flags[FlagNx] = guard_q | sticky_q;
        end
      end
      default: pack_data = a_q;
    endcase
    pack_flags[FlagZero] = (pack_data[30:0] == 31'd0);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    a_zero_d    = a_zero_q;
    a_inf_d     = a_inf_q;
    a_nan_d     = a_nan_q;
    b_zero_d    = b_zero_q;
    b_inf_d     = b_inf_q;
    b_nan_d     = b_nan_q;
    sign_d      = sign_q;
    prod_d      = prod_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_tag_d   = res_tag_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_rdata[FifoW-1 -: 2];
          a_d      = fifo_rdata[TAG_W+32 +: 32];
          b_d      = fifo_rdata[TAG_W +: 32];
          tag_d    = fifo_rdata[TAG_W-1:0];
          state_d  = StUnpack;
        end
      end
      StUnpack: begin
        // Exponent field of zero covers both true zero and flushed denormals.
        sa_d     = a_q[31];
        sb_d     = b_q[31];
        ea_d     = a_q[30:23];
        eb_d     = b_q[30:23];
        a_zero_d = (a_q[30:23] == 8'd0);
        b_zero_d = (b_q[30:23] == 8'd0);
        a_inf_d  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf_d  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan_d  = is_nan(a_q);
        b_nan_d  = is_nan(b_q);
        ma_d     = (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
        mb_d     = (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        state_d  = StMult;
      end
      StMult: begin
        prod_d  = 48'(ma_q) * 48'(mb_q);
        sign_d  = sa_q ^ sb_q;
        exp_d   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
        state_d = StNorm;
      end
      StNorm: begin
        if (prod_q[47]) begin
          mant_d   = prod_q[46:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          mant_d   = prod_q[45:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = StPack;
      end
      StPack: begin
        res_data_d  = pack_data;
        res_flags_d = pack_flags;
        res_tag_d   = tag_q;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      a_zero_q    <= 1'b0;
      a_inf_q     <= 1'b0;
      a_nan_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      b_inf_q     <= 1'b0;
      b_nan_q     <= 1'b0;
      sign_q      <= 1'b0;
      prod_q      <= '0;
      exp_q       <= '0;
      mant_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      a_zero_q    <= a_zero_d;
      a_inf_q     <= a_inf_d;
      a_nan_q     <= a_nan_d;
      b_zero_q    <= b_zero_d;
      b_inf_q     <= b_inf_d;
      b_nan_q     <= b_nan_d;
      sign_q      <= sign_d;
      prod_q      <= prod_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign res_valid = (state_q == StHold);
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_flags = res_flags_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule
